// File: rtl/alu_regfile_loader_if.sv
// Board-side bus for alu_regfile_loader: shared switch data, three load buttons,
// and the registered ALU result with its status flags.
interface alu_regfile_loader_if #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
);
    logic [NB_DATA-1:0] i_data;
    logic               i_btn_a;
    logic               i_btn_b;
    logic               i_btn_op;
    logic [NB_DATA-1:0] o_result;
    logic               o_carry;
    logic               o_overflow;
    logic               o_zero;
    logic               o_valid;

    modport master (
        output i_data, i_btn_a, i_btn_b, i_btn_op,
        input  o_result, o_carry, o_overflow, o_zero, o_valid
    );

    modport slave (
        input  i_data, i_btn_a, i_btn_b, i_btn_op,
        output o_result, o_carry, o_overflow, o_zero, o_valid
    );
endinterface

// File: rtl/alu_regfile_loader.sv
// Clocked ALU: operands and opcode are captured from a shared bus on button rising
// edges; the result and flags are registered one clock after the operand registers.
module alu_regfile_loader #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
) (
    input  logic                 clk,
    input  logic                 i_reset,
    alu_regfile_loader_if.slave  bus
);
    localparam logic [NB_OP-1:0]   OP_ADD    = NB_OP'(6'b100000);
    localparam logic [NB_OP-1:0]   OP_SUB    = NB_OP'(6'b100010);
    localparam logic [NB_OP-1:0]   OP_AND    = NB_OP'(6'b100100);
    localparam logic [NB_OP-1:0]   OP_OR     = NB_OP'(6'b100101);
    localparam logic [NB_OP-1:0]   OP_XOR    = NB_OP'(6'b100110);
    localparam logic [NB_OP-1:0]   OP_NOR    = NB_OP'(6'b100111);
    localparam logic [NB_OP-1:0]   OP_SRL    = NB_OP'(6'b000010);
    localparam logic [NB_OP-1:0]   OP_SRA    = NB_OP'(6'b000011);
    localparam logic [NB_DATA-1:0] SHIFT_LIM = NB_DATA'(NB_DATA);
    localparam int                 MSB       = NB_DATA - 1;

    logic [NB_DATA-1:0] a_q, a_d, b_q, b_d;
    logic [NB_OP-1:0]   op_q, op_d;
    logic [2:0]         loaded_q, loaded_d;
    logic [2:0]         prev_q, prev_d;
    logic [NB_DATA-1:0] result_q, result_d;
    logic               carry_q, carry_d;
    logic               ovf_q, ovf_d;
    logic               zero_q, zero_d;
    logic               valid_q, valid_d;

    logic [2:0]         btn_s;
    logic [2:0]         edge_s;
    logic [NB_DATA:0]   sum_s;
    logic [NB_DATA:0]   diff_s;
    logic [NB_DATA-1:0] alu_res_s;
    logic               alu_carry_s;
    logic               alu_ovf_s;
    logic               defined_s;

    assign btn_s  = {bus.i_btn_op, bus.i_btn_b, bus.i_btn_a};
    assign edge_s = btn_s & ~prev_q;

    // Operand/opcode capture on button rising edges and sticky loaded flags
    always_comb begin
        prev_d   = btn_s;
        loaded_d = loaded_q | edge_s;
        if (edge_s[0]) begin
            a_d = bus.i_data;
        end else begin
            a_d = a_q;
        end
        if (edge_s[1]) begin
            b_d = bus.i_data;
        end else begin
            b_d = b_q;
        end
        if (edge_s[2]) begin
            op_d = bus.i_data[NB_OP-1:0];
        end else begin
            op_d = op_q;
        end
    end

    // ALU datapath; SUB is A + ~B + 1 so its carry-out means "no borrow"
    always_comb begin
        sum_s       = {1'b0, a_q} + {1'b0, b_q};
        diff_s      = {1'b0, a_q} + {1'b0, ~b_q} + {{NB_DATA{1'b0}}, 1'b1};
        alu_res_s   = {NB_DATA{1'b0}};
        alu_carry_s = 1'b0;
        alu_ovf_s   = 1'b0;
        defined_s   = 1'b1;
        case (op_q)
            OP_ADD: begin
                alu_res_s   = sum_s[NB_DATA-1:0];
                alu_carry_s = sum_s[NB_DATA];
                alu_ovf_s   = (a_q[MSB] == b_q[MSB]) && (sum_s[MSB] != a_q[MSB]);
            end
            OP_SUB: begin
                alu_res_s   = diff_s[NB_DATA-1:0];
                alu_carry_s = diff_s[NB_DATA];
                alu_ovf_s   = (a_q[MSB] != b_q[MSB]) && (diff_s[MSB] != a_q[MSB]);
            end
            OP_AND: alu_res_s = a_q & b_q;
            OP_OR:  alu_res_s = a_q | b_q;
            OP_XOR: alu_res_s = a_q ^ b_q;
            OP_NOR: alu_res_s = ~(a_q | b_q);
            OP_SRL: begin
                if (b_q >= SHIFT_LIM) begin
                    alu_res_s = {NB_DATA{1'b0}};
                end else begin
                    alu_res_s = a_q >> b_q;
                end
            end
            OP_SRA: begin
                if (b_q >= SHIFT_LIM) begin
                    alu_res_s = {NB_DATA{a_q[MSB]}};
                end else begin
                    alu_res_s = $unsigned($signed(a_q) >>> b_q);
                end
            end
            default: defined_s = 1'b0;
        endcase
    end

    // Result/flag next state; an undefined opcode keeps the last result and flags
    always_comb begin
        valid_d = &loaded_q;
        if (defined_s) begin
            result_d = alu_res_s;
            carry_d  = alu_carry_s;
            ovf_d    = alu_ovf_s;
            zero_d   = (alu_res_s == {NB_DATA{1'b0}});
        end else begin
            result_d = result_q;
            carry_d  = carry_q;
            ovf_d    = ovf_q;
            zero_d   = zero_q;
        end
    end

    // State registers; previous-level flops reset high so a held button never loads
    always_ff @(posedge clk) begin
        if (i_reset) begin
            a_q      <= {NB_DATA{1'b0}};
            b_q      <= {NB_DATA{1'b0}};
            op_q     <= {NB_OP{1'b0}};
            loaded_q <= 3'b000;
            prev_q   <= 3'b111;
            result_q <= {NB_DATA{1'b0}};
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b1;
            valid_q  <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            loaded_q <= loaded_d;
            prev_q   <= prev_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.o_result   = result_q;
    assign bus.o_carry    = carry_q;
    assign bus.o_overflow = ovf_q;
    assign bus.o_zero     = zero_q;
    assign bus.o_valid    = valid_q;
endmodule

// File: doc/alu_regfile_loader.md
# alu_regfile_loader

Parametrised, registered successor to the combinational switch-driven ALU. It loads operand A, operand B and the 6-bit opcode from a shared data bus on button rising edges. It computes the result one clock later into a registered output with status flags. It sits between the board switch/button inputs and the LED outputs, replacing direct combinational wiring with a clocked datapath.

## Interface
Parameters:
- NB_DATA, 8, operand/result width in bits (≥ 4)
- NB_OP, 6, opcode width; opcode values below are fixed at 6 bits and zero-extended if NB_OP > 6

Ports:
- clk  input  1  system clock, all logic on rising edge
- i_reset  input  1  synchronous, active-high reset
- i_data  input  NB_DATA  shared data bus (switches); low NB_OP bits are used for opcode load
- i_btn_a  input  1  level input; rising edge loads operand A from i_data
- i_btn_b  input  1  level input; rising edge loads operand B from i_data
- i_btn_op  input  1  level input; rising edge loads opcode from i_data[NB_OP-1:0]
- o_result  output  NB_DATA  registered ALU result
- o_carry  output  1  ADD: carry-out; SUB: 1 when A ≥ B unsigned (no borrow); other ops: 0
- o_overflow  output  1  signed overflow for ADD/SUB; other ops: 0
- o_zero  output  1  1 when o_result == 0
- o_valid  output  1  1 once A, B and opcode have each been loaded at least once since reset

## Operation
- Edge detect: per button, a previous-level register; load fires when the input is high this cycle and the previous register is low. Previous registers reset to 1, so a button held through reset does not load until it is released and pressed again.
- Simultaneous edges: every button with an edge loads in the same cycle from the same i_data value.
- Loaded flags: three sticky bits, one per register, cleared by reset. o_valid is the AND of the three, registered with the result.
- Opcodes and results, with A and B from the operand registers:
  - ADD 100000: A+B mod 2^NB_DATA.
  - SUB 100010: A−B mod 2^NB_DATA, computed as A+~B+1.
  - AND 100100: A&B.
  - OR 100101: A|B.
  - XOR 100110: A^B.
  - NOR 100111: ~(A|B).
  - SRL 000010: A logically shifted right by B.
  - SRA 000011: A, treated as signed, shifted right by B with sign fill.
- Shift amount: B is treated as unsigned at full width. If B ≥ NB_DATA, SRL gives 0 and SRA gives all copies of A's MSB.
- Undefined opcode: o_result, o_carry, o_overflow and o_zero hold their previous values, with no latch.
- o_overflow: ADD sets it when A and B share a sign that differs from the result's sign. SUB sets it when A and B differ in sign and the result's sign differs from A's sign.
- Result/flag registers update every cycle from the current operand/opcode registers; there is no enable other than the undefined-opcode hold.

## Timing
- Reset, applied on a rising edge with i_reset high:
  - A, B, opcode registers: 0.
  - Loaded flags: 0.
  - o_result: 0, o_carry: 0, o_overflow: 0, o_zero: 1, o_valid: 0.
- Reset dominates any simultaneous button edge. Reset asserted mid-sequence discards all loads.
- Load latency: a button edge sampled at edge n updates the operand/opcode register at edge n. The dependent result and flags appear after edge n+1, i.e. 2 edges from the first high sample.
- o_valid rises in the same cycle the result for the third loaded item appears.
- Re-press: loading a new value after o_valid is set recomputes with 1-cycle latency. o_valid stays 1.
- Holding a button high produces exactly one load. A release of at least one cycle is required before the next load.
- No debounce in this block; inputs are already synchronised and debounced upstream.

## Test plan
- Reset, then no buttons → o_result=0x00, o_zero=1, o_carry=0, o_overflow=0, o_valid=0 indefinitely.
- Load A=0xF0, B=0x20, op=100000 (separate presses) → o_result=0x10, o_carry=1, o_overflow=0, o_zero=0, o_valid=1, two edges after the op press.
- Load A=0x05, B=0x05, op=100010 → o_result=0x00, o_zero=1, o_carry=1. Then reload B=0x06 → o_result=0xFF, o_carry=0 one cycle after the B load.
- A=0x80, op=000011: B=3 → 0xF0; B=9 → 0xFF. op=000010 with B=3 → 0x10; with B=9 → 0x00.
- A=0x7F, B=0x01, ADD → 0x80, o_overflow=1. Then load op=111111 → o_result stays 0x80 and all flags unchanged.
- Hold i_btn_a high across reset deassertion with i_data=0x33 → A not loaded (result for AND with B=0xFF stays based on A=0). Release then press → A=0x33 loads. Also press all three buttons in one cycle with i_data=0x24 → A=B=0x24, op=100100, o_result=0x24, o_valid=1.
